sc_csaddr_sequencer: RTL and testbench

Control-store next-address sequencer for the microprogrammed control unit. Holds the current microinstruction address, drives it to the control-store ROM and to the address incrementer, and each cycle picks the next address from the incremented address, the microword jump field, or the opcode decode address. The choice is made by the microword condition field and the PSR flags. An optional micro-subroutine stack adds call/return.

---
 rtl/sc_csas_pkg.sv | 35 +++
 rtl/sc_csas_ustack.sv | 45 ++++
 rtl/sc_csaddr_sequencer.sv | 149 ++++++++++++++
 tb/tb_sc_csaddr_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sc_csas_pkg.sv
// Shared definitions for the control-store address sequencer:
// condition codes, BOOT/RUN state encoding, PSR flag positions and
// the opcode decode-address builder.
package sc_csas_pkg;

  localparam int CSAS_W = 11;
  localparam int OP_W   = 8;

  // Microword branch-condition field encodings
  localparam logic [2:0] COND_NEXT   = 3'b000;
  localparam logic [2:0] COND_N      = 3'b001;
  localparam logic [2:0] COND_Z      = 3'b010;
  localparam logic [2:0] COND_V      = 3'b011;
  localparam logic [2:0] COND_C      = 3'b100;
  localparam logic [2:0] COND_IR13   = 3'b101;
  localparam logic [2:0] COND_JUMP   = 3'b110;
  localparam logic [2:0] COND_DECODE = 3'b111;

  // Bit positions inside the {n,z,v,c} PSR bus
  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Opcode dispatch lands on a 4-word aligned slot in the upper half of the store
  function automatic logic [CSAS_W-1:0] decode_addr(input logic [OP_W-1:0] op);
    return {1'b1, op, 2'b00};
  endfunction

endpackage

// File: rtl/sc_csas_ustack.sv
// Micro-return LIFO: DEPTH entries of W bits with full/empty flags.
// The parent guarantees push and pop are never asserted together and
// never push when full or pop when empty.
module sc_csas_ustack #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign top_idx  = AW'(cnt - CW'(1));
  assign wr_idx   = AW'(cnt);
  assign top_data = mem[top_idx];

  // Occupancy count and storage; reset empties and scrubs the stack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_idx] <= push_data;
      cnt         <= cnt + CW'(1);
    end else if (pop) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/sc_csaddr_sequencer.sv
// Control-store next-address sequencer. Picks INC, JUMPADDR or the
// opcode decode address per the microword condition field and PSR
// flags, and registers it as the current control-store address.
// Optional micro-subroutine stack: define USTACK_EN.
module sc_csaddr_sequencer
  import sc_csas_pkg::*;
#(
  parameter int DATAWIDTH_BUS_CSAS = 11,
  parameter int DATAWIDTH_OPCODE   = 8,
  parameter int USTACK_DEPTH       = 4
) (
  input  logic                          SC_CSAS_CLOCK_50,
  input  logic                          SC_CSAS_RESET_InLow,
  input  logic [DATAWIDTH_BUS_CSAS-1:0] SC_CSAS_INC_InBUS,
  input  logic [DATAWIDTH_BUS_CSAS-1:0] SC_CSAS_JUMPADDR_InBUS,
  input  logic [2:0]                    SC_CSAS_COND_InBUS,
  input  logic [DATAWIDTH_OPCODE-1:0]   SC_CSAS_OPCODE_InBUS,
  input  logic [3:0]                    SC_CSAS_PSR_InBUS,
  input  logic                          SC_CSAS_IR13_In,
  input  logic                          SC_CSAS_STALL_In,
  input  logic                          SC_CSAS_CALL_In,
  input  logic                          SC_CSAS_RET_In,
  output logic [DATAWIDTH_BUS_CSAS-1:0] SC_CSAS_ADDR_OutBUS,
  output logic                          SC_CSAS_VALID_Out,
  output logic                          SC_CSAS_STKERR_Out
);

  localparam int W = DATAWIDTH_BUS_CSAS;

  state_t         state_q, state_d;
  logic           upd;
  logic           taken;
  logic [W-1:0]   cond_addr;
  logic [W-1:0]   addr_q, addr_d;

  // State register
  always_ff @(posedge SC_CSAS_CLOCK_50 or negedge SC_CSAS_RESET_InLow) begin
    if (!SC_CSAS_RESET_InLow) state_q <= ST_BOOT;
    else                      state_q <= state_d;
  end

  // Next state: BOOT always falls through to RUN, stall or not
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // State outputs: live once running; address only moves in RUN without stall
  always_comb begin
    SC_CSAS_VALID_Out = 1'b0;
    upd               = 1'b0;
    if (state_q == ST_RUN) begin
      SC_CSAS_VALID_Out = 1'b1;
      upd               = !SC_CSAS_STALL_In;
    end
  end

  // Condition-field branch resolution
  always_comb begin
    taken = 1'b0;
    case (SC_CSAS_COND_InBUS)
      COND_NEXT:   taken = 1'b0;
      COND_N:      taken = SC_CSAS_PSR_InBUS[PSR_N];
      COND_Z:      taken = SC_CSAS_PSR_InBUS[PSR_Z];
      COND_V:      taken = SC_CSAS_PSR_InBUS[PSR_V];
      COND_C:      taken = SC_CSAS_PSR_InBUS[PSR_C];
      COND_IR13:   taken = SC_CSAS_IR13_In;
      COND_JUMP:   taken = 1'b1;
      default:     taken = 1'b0;
    endcase
    if (SC_CSAS_COND_InBUS == COND_DECODE)
      cond_addr = W'(decode_addr(SC_CSAS_OPCODE_InBUS));
    else if (taken)
      cond_addr = SC_CSAS_JUMPADDR_InBUS;
    else
      cond_addr = SC_CSAS_INC_InBUS;
  end

`ifdef USTACK_EN
  logic         stk_push, stk_pop, stk_full, stk_empty;
  logic [W-1:0] stk_top;
  logic         err_q, err_set;

  sc_csas_ustack #(
    .W     (W),
    .DEPTH (USTACK_DEPTH)
  ) u_ustack (
    .clk       (SC_CSAS_CLOCK_50),
    .rst_n     (SC_CSAS_RESET_InLow),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (SC_CSAS_INC_InBUS),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // CALL/RET override the condition path; a simultaneous pair falls back to it
  always_comb begin
    addr_d   = cond_addr;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    err_set  = 1'b0;
    if (SC_CSAS_CALL_In && SC_CSAS_RET_In) begin
      err_set = upd;
    end else if (SC_CSAS_CALL_In) begin
      addr_d   = SC_CSAS_JUMPADDR_InBUS;
      stk_push = upd && !stk_full;
      err_set  = upd && stk_full;
    end else if (SC_CSAS_RET_In) begin
      addr_d  = stk_empty ? SC_CSAS_INC_InBUS : stk_top;
      stk_pop = upd && !stk_empty;
      err_set = upd && stk_empty;
    end
  end

  // Sticky stack error, cleared only by reset
  always_ff @(posedge SC_CSAS_CLOCK_50 or negedge SC_CSAS_RESET_InLow) begin
    if (!SC_CSAS_RESET_InLow) err_q <= 1'b0;
    else if (err_set)         err_q <= 1'b1;
  end

  assign SC_CSAS_STKERR_Out = err_q;
`else
  localparam int unused_depth = USTACK_DEPTH;
  logic unused_ctl;
  assign unused_ctl = SC_CSAS_CALL_In ^ SC_CSAS_RET_In;

  // Without the stack the condition field alone steers sequencing
  always_comb begin
    addr_d = cond_addr;
  end

  assign SC_CSAS_STKERR_Out = 1'b0;
`endif

  // Current address register; held through BOOT and on stall
  always_ff @(posedge SC_CSAS_CLOCK_50 or negedge SC_CSAS_RESET_InLow) begin
    if (!SC_CSAS_RESET_InLow) addr_q <= '0;
    else if (upd)             addr_q <= addr_d;
  end

  assign SC_CSAS_ADDR_OutBUS = addr_q;

endmodule

// File: tb/tb_sc_csaddr_sequencer.sv
// Self-checking bench for sc_csaddr_sequencer: directed test-plan
// cases followed by randomized stimulus against a behavioural model.
// Stack cases are exercised when USTACK_EN is defined.
module tb_sc_csaddr_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] inc = '0, jump = '0;
  logic [2:0]  cond = '0;
  logic [7:0]  op = '0;
  logic [3:0]  psr = '0;
  logic        ir13 = 1'b0, stall = 1'b0, call = 1'b0, ret = 1'b0;
  logic [10:0] addr;
  logic        valid, stkerr;

  int total = 0;
  int bad = 0;

  sc_csaddr_sequencer #(
    .DATAWIDTH_BUS_CSAS (11),
    .DATAWIDTH_OPCODE   (8),
    .USTACK_DEPTH       (DEPTH)
  ) dut (
    .SC_CSAS_CLOCK_50       (clk),
    .SC_CSAS_RESET_InLow    (rst_n),
    .SC_CSAS_INC_InBUS      (inc),
    .SC_CSAS_JUMPADDR_InBUS (jump),
    .SC_CSAS_COND_InBUS     (cond),
    .SC_CSAS_OPCODE_InBUS   (op),
    .SC_CSAS_PSR_InBUS      (psr),
    .SC_CSAS_IR13_In        (ir13),
    .SC_CSAS_STALL_In       (stall),
    .SC_CSAS_CALL_In        (call),
    .SC_CSAS_RET_In         (ret),
    .SC_CSAS_ADDR_OutBUS    (addr),
    .SC_CSAS_VALID_Out      (valid),
    .SC_CSAS_STKERR_Out     (stkerr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: running flag, expected address, sticky error, return queue
  logic [10:0] m_addr = '0;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  logic [10:0] m_stk [$];

  always @(posedge clk or negedge rst_n) begin
    logic [10:0] nxt;
    logic        hit;
    if (!rst_n) begin
      m_addr = '0; m_valid = 1'b0; m_err = 1'b0; m_stk.delete();
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (!stall) begin
      hit = (cond == 3'd6) || (cond == 3'd1 && psr[3]) || (cond == 3'd2 && psr[2]) ||
            (cond == 3'd3 && psr[1]) || (cond == 3'd4 && psr[0]) || (cond == 3'd5 && ir13);
      if (cond == 3'd7) nxt = {1'b1, op, 2'b00};
      else              nxt = hit ? jump : inc;
`ifdef USTACK_EN
      if (call && ret) m_err = 1'b1;
      else if (call) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(inc);
        else m_err = 1'b1;
        nxt = jump;
      end else if (ret) begin
        if (m_stk.size() > 0) nxt = m_stk.pop_back();
        else begin nxt = inc; m_err = 1'b1; end
      end
`endif
      m_addr = nxt;
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    check("cyc_addr", {21'd0, addr}, {21'd0, m_addr});
    check("cyc_valid", {31'd0, valid}, {31'd0, m_valid});
    check("cyc_stkerr", {31'd0, stkerr}, {31'd0, m_err});
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_addr", {21'd0, addr}, 32'h000);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_stkerr", {31'd0, stkerr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; cond = 3'd0; inc = 11'h001;
    step;
    check("boot_addr", {21'd0, addr}, 32'h000);
    check("boot_valid", {31'd0, valid}, 32'd1);
    step;
    check("first_inc", {21'd0, addr}, 32'h001);

    cond = 3'd2; jump = 11'h123; psr = 4'b0100; inc = 11'h124;
    step;
    check("z_taken", {21'd0, addr}, 32'h123);
    psr = 4'b0000;
    step;
    check("z_not_taken", {21'd0, addr}, 32'h124);

    cond = 3'd7; op = 8'hA5;
    step;
    check("decode", {21'd0, addr}, 32'h694);
    check("model_decode", {21'd0, m_addr}, 32'h694);
    stall = 1'b1; cond = 3'd6; jump = 11'h555;
    step;
    check("stall_hold", {21'd0, addr}, 32'h694);
    stall = 1'b0;

`ifdef USTACK_EN
    cond = 3'd0; call = 1'b1; jump = 11'h200; inc = 11'h011;
    step;
    check("call_jump", {21'd0, addr}, 32'h200);
    call = 1'b0; inc = 11'h201;
    step;
    check("in_sub", {21'd0, addr}, 32'h201);
    ret = 1'b1; inc = 11'h202;
    step;
    check("ret_addr", {21'd0, addr}, 32'h011);
    check("ret_noerr", {31'd0, stkerr}, 32'd0);
    ret = 1'b0;
    for (int i = 0; i < 5; i++) begin
      call = 1'b1; jump = 11'h300 + 11'(i); inc = 11'h040 + 11'(i);
      step;
      check("call_n", {21'd0, addr}, 32'h300 + i);
    end
    check("overflow_err", {31'd0, stkerr}, 32'd1);
    call = 1'b0;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    ret = 1'b1; inc = 11'h055;
    step;
    check("underflow_addr", {21'd0, addr}, 32'h055);
    check("underflow_err", {31'd0, stkerr}, 32'd1);
    ret = 1'b0;
`endif

    cond = 3'd6; jump = 11'h3F0;
    step;
    check("pre_reset", {21'd0, addr}, 32'h3F0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_addr", {21'd0, addr}, 32'h000);
    check("async_rst_valid", {31'd0, valid}, 32'd0);
    step;
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      cond  = 3'($urandom_range(0, 7));
      jump  = 11'($urandom);
      inc   = ($urandom_range(0, 3) == 0) ? 11'($urandom) : m_addr + 11'd1;
      op    = 8'($urandom);
      psr   = 4'($urandom);
      ir13  = 1'($urandom);
      stall = ($urandom_range(0, 7) == 0);
      call  = ($urandom_range(0, 6) == 0);
      ret   = ($urandom_range(0, 6) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      step;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
